// File: rtl/p4_router_ingress_arbiter.sv
// ---------------------------------------------------------------------------
// p4_router_ingress_arbiter
//
// Packet-granular round-robin arbiter that merges NUM_PORTS ingress
// AXI-Stream sources into the single packet input of the P4 match-action
// engine (VNP4 wrapper). Once a port is granted, its packet is passed through
// combinationally (no added data latency) until the tlast handshake. For each
// packet the block emits user metadata {egr_spec = 0, ing_port = RTL ingress
// index} plus a metadata-valid strobe on the first beat.
//
// Ports:
//   clk                 - single clock
//   sreset              - synchronous, active-high reset
//   port_enable         - per-port arbitration enable (sampled at arbitration)
//   in_tdata/tkeep/
//   in_tlast/tvalid     - ingress AXI-Stream, one lane per port
//   in_tready           - ingress ready, only the granted port sees out_tready
//   out_tdata/tkeep/
//   out_tlast/tvalid    - merged stream to the VNP4
//   out_tready          - ready from the VNP4
//   user_metadata       - {egr_spec, ing_port}
//   user_metadata_valid - high with the first beat of each packet
//   pkt_count           - per-port forwarded packet counters (wrapping)
// ---------------------------------------------------------------------------
module p4_router_ingress_arbiter #(
    parameter int NUM_PORTS         = 11,
    parameter int DATA_BYTES        = 8,
    parameter int ING_PORT_ID_WIDTH = 8,
    parameter int EGR_SPEC_ID_WIDTH = 8,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                                     clk,
    input  logic                                     sreset,
    input  logic [NUM_PORTS-1:0]                     port_enable,
    input  logic [NUM_PORTS-1:0][DATA_BYTES*8-1:0]   in_tdata,
    input  logic [NUM_PORTS-1:0][DATA_BYTES-1:0]     in_tkeep,
    input  logic [NUM_PORTS-1:0]                     in_tlast,
    input  logic [NUM_PORTS-1:0]                     in_tvalid,
    output logic [NUM_PORTS-1:0]                     in_tready,
    output logic [DATA_BYTES*8-1:0]                  out_tdata,
    output logic [DATA_BYTES-1:0]                    out_tkeep,
    output logic                                     out_tlast,
    output logic                                     out_tvalid,
    input  logic                                     out_tready,
    output logic [ING_PORT_ID_WIDTH+EGR_SPEC_ID_WIDTH-1:0] user_metadata,
    output logic                                     user_metadata_valid,
    output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]      pkt_count
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

    typedef enum logic {IDLE, PASS} state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       grant, grant_nxt;
    logic [GW-1:0]       last_grant, last_grant_nxt;
    logic                first_beat, first_beat_nxt;
    logic                count_en;
    logic [NUM_PORTS-1:0] req;

    // Round-robin pick: first requester after 'last', wrapping modulo
    // NUM_PORTS. The loop runs from the lowest priority offset down to the
    // highest so the highest-priority requester is written last and wins.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                              input logic [GW-1:0]        last);
        logic [GW-1:0] pick;
        int            idx;
        pick = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_PORTS;
            if (r[idx]) pick = GW'(idx);
        end
        return pick;
    endfunction

    always_ff @(posedge clk) begin
        if (sreset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_PORT;
            first_beat <= 1'b1;
            pkt_count  <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            first_beat <= first_beat_nxt;
            if (count_en)
                pkt_count[grant] <= pkt_count[grant] + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_nxt           = state;
        grant_nxt           = grant;
        last_grant_nxt      = last_grant;
        first_beat_nxt      = first_beat;
        count_en            = 1'b0;
        in_tready           = '0;
        out_tdata           = '0;
        out_tkeep           = '0;
        out_tlast           = 1'b0;
        out_tvalid          = 1'b0;
        user_metadata       = '0;
        user_metadata_valid = 1'b0;
        req                 = in_tvalid & port_enable;

        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = rr_pick(req, last_grant);
                    state_nxt = PASS;
                end
            end
            PASS: begin
                // out_tvalid depends only on the source, never on out_tready.
                out_tdata           = in_tdata[grant];
                out_tkeep           = in_tkeep[grant];
                out_tlast           = in_tlast[grant];
                out_tvalid          = in_tvalid[grant];
                in_tready[grant]    = out_tready;
                user_metadata       = {{EGR_SPEC_ID_WIDTH{1'b0}},
                                       ING_PORT_ID_WIDTH'(grant)};
                user_metadata_valid = in_tvalid[grant] & first_beat;
                if (in_tvalid[grant] && out_tready) begin
                    first_beat_nxt = 1'b0;
                    if (in_tlast[grant]) begin
                        first_beat_nxt = 1'b1;
                        last_grant_nxt = grant;
                        count_en       = 1'b1;
                        state_nxt      = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Quiet outputs during reset so a partial packet is cut off cleanly.
        if (sreset) begin
            in_tready           = '0;
            out_tdata           = '0;
            out_tkeep           = '0;
            out_tlast           = 1'b0;
            out_tvalid          = 1'b0;
            user_metadata       = '0;
            user_metadata_valid = 1'b0;
            count_en            = 1'b0;
        end
    end

endmodule

// File: tb/tb_p4_router_ingress_arbiter.sv
module tb_p4_router_ingress_arbiter;

    localparam int NP = 11;
    localparam int DB = 8;
    localparam int IW = 8;
    localparam int EW = 8;
    localparam int CW = 2;

    logic                     clk = 1'b0;
    logic                     sreset;
    logic [NP-1:0]            port_enable;
    logic [NP-1:0][DB*8-1:0]  in_tdata;
    logic [NP-1:0][DB-1:0]    in_tkeep;
    logic [NP-1:0]            in_tlast;
    logic [NP-1:0]            in_tvalid;
    logic [NP-1:0]            in_tready;
    logic [DB*8-1:0]          out_tdata;
    logic [DB-1:0]            out_tkeep;
    logic                     out_tlast;
    logic                     out_tvalid;
    logic                     out_tready;
    logic [IW+EW-1:0]         user_metadata;
    logic                     user_metadata_valid;
    logic [NP-1:0][CW-1:0]    pkt_count;

    always #5 clk = ~clk;

    p4_router_ingress_arbiter #(
        .NUM_PORTS(NP), .DATA_BYTES(DB), .ING_PORT_ID_WIDTH(IW),
        .EGR_SPEC_ID_WIDTH(EW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .sreset(sreset), .port_enable(port_enable),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .user_metadata(user_metadata), .user_metadata_valid(user_metadata_valid),
        .pkt_count(pkt_count)
    );

    typedef struct {
        logic [DB*8-1:0] data;
        logic [DB-1:0]   keep;
        logic            last;
        int              port;
        logic            first;
    } beat_t;

    typedef struct {
        logic [NP-1:0] valid;
        logic [NP-1:0] en;
        logic          exp_v;
        int            exp_port;
    } arb_vec_t;

    beat_t    sb_q[$];
    arb_vec_t vecs[6];

    int checks   = 0;
    int failures = 0;

    // Source model state per port
    int len[NP];
    int left[NP];
    int pk[NP];
    int bt[NP];
    int exp_cnt[NP];

    // Values sampled at the falling edge of the last tick
    logic            s_tvalid, s_mvalid, s_tlast;
    logic [IW-1:0]   s_port;
    logic [DB*8-1:0] s_tdata;
    logic [NP-1:0]   s_tready;
    logic [IW+EW-1:0] s_meta;

    function automatic logic [DB*8-1:0] bdata(input int p, input int k, input int b);
        return {8'(p), 8'(k), 8'(b), 40'h5A_C3_96_3C_E1};
    endfunction

    function automatic logic [DB-1:0] bkeep(input logic last);
        return last ? 8'h1F : 8'hFF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            in_tvalid[p] = (left[p] > 0);
            in_tdata[p]  = bdata(p, pk[p], bt[p]);
            in_tlast[p]  = (bt[p] == len[p] - 1);
            in_tkeep[p]  = bkeep(bt[p] == len[p] - 1);
        end
    endtask

    task automatic push_pkt(input int p, input int k, input int n);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.data  = bdata(p, k, b);
            e.keep  = bkeep(b == n - 1);
            e.last  = (b == n - 1);
            e.port  = p;
            e.first = (b == 0);
            sb_q.push_back(e);
        end
        exp_cnt[p] = (exp_cnt[p] + 1) % (1 << CW);
    endtask

    task automatic tick();
        logic [NP-1:0] hs;
        beat_t e;
        @(negedge clk);
        s_tvalid = out_tvalid;
        s_mvalid = user_metadata_valid;
        s_tlast  = out_tlast;
        s_port   = user_metadata[IW-1:0];
        s_meta   = user_metadata;
        s_tdata  = out_tdata;
        s_tready = in_tready;
        chk("mvalid_gate", 64'(user_metadata_valid & ~out_tvalid), 64'd0);
        if (out_tvalid && out_tready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data 0x%0h port %0d expected no beat",
                         out_tdata, user_metadata[IW-1:0]);
            end else begin
                e = sb_q.pop_front();
                chk("beat_data",  64'(out_tdata), 64'(e.data));
                chk("beat_keep",  64'(out_tkeep), 64'(e.keep));
                chk("beat_last",  64'(out_tlast), 64'(e.last));
                chk("beat_port",  64'(user_metadata[IW-1:0]), 64'(e.port));
                chk("beat_egr",   64'(user_metadata[IW+EW-1:IW]), 64'd0);
                chk("beat_mvalid", 64'(user_metadata_valid), 64'(e.first));
            end
        end
        hs = in_tvalid & in_tready;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                if (bt[p] == len[p] - 1) begin
                    bt[p] = 0;
                    pk[p]++;
                    left[p]--;
                end else begin
                    bt[p]++;
                end
            end
        end
        drive();
    endtask

    task automatic clear_sources();
        for (int p = 0; p < NP; p++) begin
            left[p] = 0; pk[p] = 0; bt[p] = 0; len[p] = 1; exp_cnt[p] = 0;
        end
        sb_q.delete();
        drive();
    endtask

    task automatic do_reset();
        sreset      = 1'b1;
        out_tready  = 1'b0;
        port_enable = '1;
        clear_sources();
        tick();
        chk("rst_tvalid", 64'(s_tvalid), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_meta",   64'(s_meta),   64'd0);
        tick();
        sreset = 1'b0;
        for (int p = 0; p < NP; p++) chk("rst_count", 64'(pkt_count[p]), 64'd0);
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (sb_q.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        chk(name, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_counts(input string name);
        for (int p = 0; p < NP; p++) chk(name, 64'(pkt_count[p]), 64'(exp_cnt[p]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{valid: 11'h7FF, en: 11'h7FF, exp_v: 1'b1, exp_port: 0};
        vecs[1] = '{valid: 11'h050, en: 11'h7EF, exp_v: 1'b1, exp_port: 6};
        vecs[2] = '{valid: 11'h400, en: 11'h7FF, exp_v: 1'b1, exp_port: 10};
        vecs[3] = '{valid: 11'h028, en: 11'h7FF, exp_v: 1'b1, exp_port: 3};
        vecs[4] = '{valid: 11'h7FF, en: 11'h7FE, exp_v: 1'b1, exp_port: 1};
        vecs[5] = '{valid: 11'h010, en: 11'h7EF, exp_v: 1'b0, exp_port: 0};

        sreset = 1'b1;
        out_tready = 1'b0;
        port_enable = '1;
        clear_sources();

        // Table: first grant after reset, out_tready held low
        for (int i = 0; i < 6; i++) begin
            do_reset();
            port_enable = vecs[i].en;
            for (int p = 0; p < NP; p++) begin
                len[p]  = 1;
                left[p] = vecs[i].valid[p] ? 1 : 0;
            end
            drive();
            tick();
            chk("vec_idle_tvalid", 64'(s_tvalid), 64'd0);
            tick();
            chk("vec_tvalid", 64'(s_tvalid), 64'(vecs[i].exp_v));
            chk("vec_tready", 64'(s_tready), 64'd0);
            if (vecs[i].exp_v) begin
                chk("vec_port",   64'(s_port),   64'(vecs[i].exp_port));
                chk("vec_mvalid", 64'(s_mvalid), 64'd1);
            end
        end

        // Single 4-beat packet on port 3
        do_reset();
        out_tready = 1'b1;
        len[3] = 4; left[3] = 1;
        push_pkt(3, 0, 4);
        drive();
        tick();
        chk("t1_lat_idle", 64'(s_tvalid), 64'd0);
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("t1_tvalid", 64'(s_tvalid), 64'd1);
            chk("t1_mvalid", 64'(s_mvalid), 64'(b == 0));
        end
        tick();
        chk("t1_after", 64'(s_tvalid), 64'd0);
        chk("t1_sb_empty", 64'(sb_q.size()), 64'd0);
        check_counts("t1_count");

        // Ports 0,5,10 with two 2-beat packets each
        do_reset();
        out_tready = 1'b1;
        len[0] = 2; len[5] = 2; len[10] = 2;
        left[0] = 2; left[5] = 2; left[10] = 2;
        for (int k = 0; k < 2; k++) begin
            push_pkt(0, k, 2);
            push_pkt(5, k, 2);
            push_pkt(10, k, 2);
        end
        drive();
        n = 0;
        while (sb_q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        chk("t2_cycles", 64'(n), 64'd18);
        check_counts("t2_count");

        // All ports, single-beat packets: order wraps from 10 back to 0
        do_reset();
        out_tready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            len[p] = 1; left[p] = 2;
        end
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) push_pkt(p, k, 1);
        drive();
        drain("t3_drain", 100);
        check_counts("t3_count");

        // Backpressure on port 2
        do_reset();
        len[2] = 3; left[2] = 1;
        push_pkt(2, 0, 3);
        out_tready = 1'b0;
        drive();
        tick();
        chk("t4_idle", 64'(s_tvalid), 64'd0);
        tick();
        chk("t4_hold0_v",  64'(s_tvalid), 64'd1);
        chk("t4_hold0_m",  64'(s_mvalid), 64'd1);
        chk("t4_hold0_d",  64'(s_tdata),  64'(bdata(2, 0, 0)));
        tick();
        chk("t4_hold1_m",  64'(s_mvalid), 64'd1);
        chk("t4_hold1_d",  64'(s_tdata),  64'(bdata(2, 0, 0)));
        out_tready = 1'b1;
        tick();
        out_tready = 1'b0;
        tick();
        chk("t4_b1_d",     64'(s_tdata),  64'(bdata(2, 0, 1)));
        chk("t4_b1_m",     64'(s_mvalid), 64'd0);
        chk("t4_b1_rdy",   64'(s_tready), 64'd0);
        tick();
        chk("t4_b1_hold",  64'(s_tdata),  64'(bdata(2, 0, 1)));
        out_tready = 1'b1;
        drain("t4_drain", 10);
        check_counts("t4_count");

        // Port 4 disabled, port 6 enabled then disabled mid-packet
        do_reset();
        out_tready = 1'b1;
        port_enable = 11'h7EF;
        len[4] = 3; left[4] = 1;
        len[6] = 3; left[6] = 1;
        push_pkt(6, 0, 3);
        drive();
        tick();
        tick();
        port_enable[6] = 1'b0;
        drain("t5_drain", 10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_grant", 64'(s_tvalid), 64'd0);
        end
        port_enable[4] = 1'b1;
        push_pkt(4, 0, 3);
        drain("t5_port4", 10);
        check_counts("t5_count");

        // Reset on beat 2 of a 5-beat packet on port 1
        do_reset();
        out_tready = 1'b1;
        len[1] = 5; left[1] = 1;
        push_pkt(1, 0, 5);
        drive();
        tick();
        tick();
        sreset = 1'b1;
        tick();
        chk("t6_tvalid", 64'(s_tvalid), 64'd0);
        chk("t6_tready", 64'(s_tready), 64'd0);
        chk("t6_mvalid", 64'(s_mvalid), 64'd0);
        chk("t6_tdata",  64'(s_tdata),  64'd0);
        sreset = 1'b0;
        clear_sources();
        for (int p = 0; p < NP; p++) chk("t6_count", 64'(pkt_count[p]), 64'd0);
        tick();
        chk("t6_idle", 64'(s_tvalid), 64'd0);

        // Counter wrap: 5 packets on port 1 with a 2-bit counter
        len[1] = 2; left[1] = 5;
        for (int k = 0; k < 5; k++) push_pkt(1, k, 2);
        drive();
        drain("t7_drain", 40);
        chk("t7_wrap", 64'(pkt_count[1]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
